// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A 16-bit word (four hex nibbles) plus per-digit blank and decimal-point
// masks is accepted through a valid/ready handshake into a pending buffer.
// The pending buffer is copied to the shadow registers only at a frame
// boundary, so a digit never changes part-way through a scan. All display
// outputs are registered and active-low.
//
// Parameters
//   SCAN_DIV   clock cycles each digit stays selected (>= 2)
//   DEAD       leading cycles of every dwell with all anodes off (< SCAN_DIV)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   disp_data   four hex digits, digit3 = [15:12] ... digit0 = [3:0]
//   blank_mask  bit i = 1 blanks digit i (sampled with disp_data)
//   dp_mask     bit i = 1 lights the decimal point of digit i
//   disp_valid  load request
//   disp_ready  pending buffer empty
//   an          anode enables, active-low, bit i = digit i
//   seg         segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick  one-cycle pulse at the start of each frame
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] disp_data,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  dp_mask,
    input  logic        disp_valid,
    output logic        disp_ready,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int                DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]  DEAD_C   = DIV_W'(DEAD);

    // Active-low hex decode in {g,f,e,d,c,b,a} order.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Scan counters
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;

    // Pending buffer
    logic             pend_full_q, pend_full_d;
    logic [15:0]      pend_data_q, pend_data_d;
    logic [3:0]       pend_blank_q, pend_blank_d;
    logic [3:0]       pend_dp_q, pend_dp_d;

    // Shadow registers (display source)
    logic [15:0]      sh_data_q, sh_data_d;
    logic [3:0]       sh_blank_q, sh_blank_d;
    logic [3:0]       sh_dp_q, sh_dp_d;

    // Registered outputs
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_tick_q, frame_tick_d;

    logic             dwell_end;
    logic             boundary;
    logic             xfer;
    logic [3:0]       nibble;
    logic             digit_blank;

    always_comb begin
        dwell_end = (div_q == DIV_LAST);
        boundary  = dwell_end && (idx_q == 2'd3);
        // Ready is purely registered state, so xfer never loops back to ready.
        xfer      = disp_valid && !pend_full_q;

        div_d = dwell_end ? '0 : div_q + 1'b1;
        idx_d = dwell_end ? idx_q + 2'd1 : idx_q;

        pend_full_d  = pend_full_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        sh_data_d    = sh_data_q;
        sh_blank_d   = sh_blank_q;
        sh_dp_d      = sh_dp_q;

        // A commit needs pend_full already set, which means xfer is blocked in
        // the same cycle; a capture on an empty-buffer boundary therefore waits
        // for the next boundary.
        if (boundary && pend_full_q) begin
            sh_data_d   = pend_data_q;
            sh_blank_d  = pend_blank_q;
            sh_dp_d     = pend_dp_q;
            pend_full_d = 1'b0;
        end else if (xfer) begin
            pend_data_d  = disp_data;
            pend_blank_d = blank_mask;
            pend_dp_d    = dp_mask;
            pend_full_d  = 1'b1;
        end

        nibble      = sh_data_q[{idx_q, 2'b00} +: 4];
        digit_blank = sh_blank_q[idx_q];

        if (digit_blank || (div_q < DEAD_C)) begin
            an_d = 4'b1111;
        end else begin
            an_d = ~(4'b0001 << idx_q);
        end

        if (digit_blank) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = {~sh_dp_q[idx_q], hex_to_seg(nibble)};
        end

        frame_tick_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            idx_q        <= 2'd0;
            pend_full_q  <= 1'b0;
            pend_data_q  <= 16'h0000;
            pend_blank_q <= 4'b0000;
            pend_dp_q    <= 4'b0000;
            sh_data_q    <= 16'h0000;
            sh_blank_q   <= 4'b1111;
            sh_dp_q      <= 4'b0000;
            an_q         <= 4'b1111;
            seg_q        <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            pend_full_q  <= pend_full_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            sh_data_q    <= sh_data_d;
            sh_blank_q   <= sh_blank_d;
            sh_dp_q      <= sh_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign disp_ready = ~pend_full_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Scoreboard bench for seg7_scan_driver with SCAN_DIV = 8, DEAD = 2.
// Expected outputs come from a cycle-count based reference: every accepted
// load is recorded with the cycle it was taken and the frame boundary that
// commits it; the visible digit, dwell position and ready state are derived
// from the cycle number with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int SD    = 8;
    localparam int DT    = 2;
    localparam int FRAME = 4 * SD;

    localparam logic [6:0] DEC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] disp_data = 16'h0000;
    logic [3:0]  blank_mask = 4'h0;
    logic [3:0]  dp_mask = 4'h0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    seg7_scan_driver #(.SCAN_DIV(SD), .DEAD(DT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_data  (disp_data),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [3:0] an;
        logic [7:0] seg;
        logic       ft;
        logic       rdy;
    } exp_t;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  bl;
        logic [3:0]  dp;
        int          t;   // cycle the transfer happened
        int          b;   // boundary cycle that commits it
    } load_t;

    exp_t  exp_q[$];
    load_t loads[$];

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic        src_v  = 1'b0;
    logic [15:0] src_d  = 16'h0;
    logic [3:0]  src_bl = 4'h0;
    logic [3:0]  src_dp = 4'h0;

    // Ready is low from the cycle after a transfer up to and including its
    // commit boundary.
    function automatic logic model_ready(int c);
        if (loads.size() == 0) return 1'b1;
        return !((loads[$].t < c) && (c <= loads[$].b));
    endfunction

    function automatic exp_t expect_at(int c);
        exp_t        e;
        int          p, d, i;
        logic [15:0] sd;
        logic [3:0]  sb, sp, nib;
        e.c   = c;
        e.rdy = model_ready(c);
        e.ft  = 1'b0;
        e.an  = 4'hF;
        e.seg = 8'hFF;
        if (c == 0) return e;
        p  = c - 1;
        d  = p % SD;
        i  = (p / SD) % 4;
        sd = 16'h0000;
        sb = 4'hF;
        sp = 4'h0;
        foreach (loads[k]) begin
            if (loads[k].b < p) begin
                sd = loads[k].d;
                sb = loads[k].bl;
                sp = loads[k].dp;
            end
        end
        e.ft = ((c % FRAME) == 0);
        if (!sb[i]) begin
            nib   = 4'((sd >> (4 * i)) & 16'hF);
            e.seg = {~sp[i], DEC[nib]};
            if (d >= DT) e.an = 4'(~(1 << i));
        end
        return e;
    endfunction

    // One clock cycle: drive the source, record the expectation, advance.
    task automatic step();
        load_t l;
        disp_valid = src_v;
        disp_data  = src_d;
        blank_mask = src_bl;
        dp_mask    = src_dp;
        exp_q.push_back(expect_at(cyc));
        if (src_v && model_ready(cyc)) begin
            l.d  = src_d;
            l.bl = src_bl;
            l.dp = src_dp;
            l.t  = cyc;
            l.b  = ((cyc + 1) / FRAME) * FRAME + FRAME - 1;
            loads.push_back(l);
            src_v = 1'b0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] dp);
        int n;
        src_d  = d;
        src_bl = bl;
        src_dp = dp;
        src_v  = 1'b1;
        n = 0;
        while (src_v && n < 200) begin
            step();
            n++;
        end
        if (src_v) begin
            n_vec++;
            n_miss++;
            $display("FAIL offer_timeout data=%h still pending after %0d cycles, required acceptance", d, n);
            src_v = 1'b0;
        end
    endtask

    task automatic chk_reset(input string tag);
        n_vec++;
        if (an !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0 || disp_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL %s got an=%b seg=%h tick=%b rdy=%b, want an=1111 seg=ff tick=0 rdy=1",
                     tag, an, seg, frame_tick, disp_ready);
        end
    endtask

    // Monitor: the DUT presents a fresh output every cycle; compare mid-cycle.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (an !== e.an || seg !== e.seg || frame_tick !== e.ft || disp_ready !== e.rdy) begin
                n_miss++;
                $display("FAIL out cyc%0d got an=%b seg=%h tick=%b rdy=%b, want an=%b seg=%h tick=%b rdy=%b",
                         e.c, an, seg, frame_tick, disp_ready, e.an, e.seg, e.ft, e.rdy);
            end
        end
    end

    initial begin
        int n;

        // Power-on reset
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;
        cyc   = 0;

        // Load and display 1234 right after reset
        offer(16'h1234, 4'b0000, 4'b0000);
        idle(70);

        // Back-pressure: B waits behind A
        offer(16'hAAAA, 4'b0000, 4'b0000);
        offer(16'hBBBB, 4'b0000, 4'b0000);
        idle(70);

        // Blank and decimal-point masks
        offer(16'h5678, 4'b1000, 4'b0001);
        idle(70);

        // Transfer exactly on a boundary cycle with the buffer empty
        n = 0;
        while (!(((cyc % FRAME) == FRAME - 1) && model_ready(cyc)) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_miss++;
            $display("FAIL boundary_wait no empty boundary within %0d cycles, required one", n);
        end
        src_d  = 16'h0F1E;
        src_bl = 4'b0000;
        src_dp = 4'b0100;
        src_v  = 1'b1;
        step();
        idle(80);

        // Decode sweep
        offer(16'h3210, 4'b0000, 4'b0000);
        offer(16'h7654, 4'b0000, 4'b0000);
        offer(16'hBA98, 4'b0000, 4'b0000);
        offer(16'hFEDC, 4'b0000, 4'b0000);
        idle(70);

        // Random traffic; data may change while not ready and must be ignored
        for (int k = 0; k < 700; k++) begin
            if (!src_v && $urandom_range(0, 3) == 0) begin
                src_v  = 1'b1;
                src_d  = 16'($urandom);
                src_bl = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
                src_dp = 4'($urandom);
            end else if (src_v && !model_ready(cyc) && $urandom_range(0, 1) == 1) begin
                src_d  = 16'($urandom);
                src_bl = 4'($urandom);
                src_dp = 4'($urandom);
            end
            step();
        end
        src_v = 1'b0;
        idle(70);

        // Reset asserted mid-frame with a load pending and valid high
        offer(16'hC0DE, 4'b0101, 4'b1010);
        src_d  = 16'h4321;
        src_v  = 1'b1;
        idle(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        src_v      = 1'b0;
        disp_valid = 1'b0;
        loads.delete();
        repeat (3) @(negedge clk);
        chk_reset("reset_hold");
        rst_n = 1'b1;
        cyc   = 0;
        idle(70);

        offer(16'h9E5A, 4'b0010, 4'b1001);
        idle(70);

        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the 16-bit 4:1 display-source mux and takes the selected 16-bit word as four hex nibbles. The word is captured through a valid/ready handshake into a pending buffer. It is committed to the display only at a frame boundary, so a digit never tears mid-scan. The block produces registered active-low anode and segment drives.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit is selected (dwell); must be ≥ 2.
- `DEAD`, default 16: ghosting dead-time; for the first `DEAD` cycles of each dwell, all anodes are off. Must satisfy 0 ≤ `DEAD` < `SCAN_DIV`.
- `clk` input, 1 bit: single system clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `disp_data` input, 16 bits: four hex digits; digit3 = [15:12], digit0 = [3:0].
- `blank_mask` input, 4 bits: bit i = 1 blanks digit i; sampled together with `disp_data`.
- `dp_mask` input, 4 bits: bit i = 1 lights the decimal point of digit i; sampled together with `disp_data`.
- `disp_valid` input, 1 bit: load request.
- `disp_ready` output, 1 bit: pending buffer is empty.
- `an` output, 4 bits: anode enables, active-low; bit i drives digit i.
- `seg` output, 8 bits: active-low segments {dp, g, f, e, d, c, b, a}.
- `frame_tick` output, 1 bit: one-cycle pulse at the start of each frame.

## Operation
- **Divider:** `div` counts 0 to `SCAN_DIV`-1 and wraps. Digit index `idx` (2 bits) advances when `div` = `SCAN_DIV`-1, wrapping 3 to 0.
- **Frame boundary:** the cycle with `idx` = 3 and `div` = `SCAN_DIV`-1. Frame length is 4·`SCAN_DIV` cycles.
- **Handshake:**
  - A transfer occurs when `disp_valid` and `disp_ready` are both 1. It captures {`disp_data`, `blank_mask`, `dp_mask`} into the pending buffer and sets `pend_full`.
  - `disp_ready` = ~`pend_full`, registered state with no combinational path from `disp_valid`.
  - `disp_valid` while `disp_ready` = 0 is ignored; the source must hold it.
- **Commit:** on the frame-boundary edge, if `pend_full` = 1, the pending buffer is copied to the shadow registers and `pend_full` is cleared. The shadow registers are the only source for display.
- **Simultaneous transfer and boundary with the buffer empty:** the data is captured into pending and committed at the next boundary, not the current one.
- **Output generation (registered):**
  - `an` = 4'b1111 if `div` < `DEAD` or `blank_mask_sh`[`idx`] = 1; otherwise only bit `idx` is low.
  - `seg`[7] = ~`dp_mask_sh`[`idx`].
  - `seg`[6:0] = active-low hex decode of nibble `idx`. In {g..a} form:
    - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78 (hex)
    - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
  - When the digit is blanked, `seg` = 8'hFF.
- **frame_tick:** registered; high for exactly the one cycle after the frame-boundary edge, whether or not a commit happened.

## Timing
- **Reset values:**
  - outputs: `an` = 4'b1111, `seg` = 8'hFF, `frame_tick` = 0, `disp_ready` = 1
  - counters: `div` = 0, `idx` = 0, `pend_full` = 0
  - shadow registers: data = 0, blank = 4'b1111 (display dark until the first commit), dp = 0
- **Reset assertion:** asynchronous, mid-frame or mid-handshake; any pending data is discarded.
- **Output latency:** `an`/`seg` in cycle t+1 reflect `div`, `idx` and the shadow registers in cycle t. New shadow contents first appear on `an`/`seg` 2 cycles after the boundary edge.
- **Transfer to display:** worst case about 4·`SCAN_DIV` + 2 cycles; best case 3 cycles when the transfer lands one cycle before a boundary.
- **Back-to-back loads:** throughput is one load per frame. `disp_ready` rises the cycle after the commit edge.

## Test plan
All scenarios use `SCAN_DIV` = 8 and `DEAD` = 2.
- **Reset:** assert `rst_n` = 0 mid-stream → `an` = 1111, `seg` = FF, `disp_ready` = 1 immediately. After release, the first frame stays dark, and `frame_tick` pulses at cycle 32 and every 32 cycles after.
- **Load and display:** load 16'h1234 with blank = 0, dp = 0 right after reset → commit at the first boundary. In the next frame:
  - digit0: `an` = 1110 for `div` 2..7 (1111 for `div` 0..1), `seg` = 8'h99
  - digit1: `seg` = 8'hB0
  - digit2: `seg` = 8'hA4
  - digit3: `seg` = 8'hF9
- **Back-pressure:** offer A (16'hAAAA), then B (16'hBBBB) within one frame → `disp_ready` = 0 after A and B is held. A is displayed; B is accepted in the cycle after the commit and shown one frame later.
- **Masks:** blank = 4'b1000, dp = 4'b0001 → digit3 `an` stays 1111 for its whole dwell; digit0 `seg`[7] = 0; other digits' `seg`[7] = 1.
- **Boundary collision:** with the buffer empty, assert `disp_valid` exactly on the boundary cycle → captured but not committed; displayed only after the following boundary.
- **Decode sweep:** load 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC in successive frames → all 16 `seg` patterns match the decode list.
